core_ctrl: RTL
==============

# core_ctrl

Multi-cycle sequencer for the single-issue RV32I core. It owns the program counter and the instruction register. It steps each instruction through FETCH, DECODE, EXECUTE, optional MEM and WRITEBACK, with ready/ack handshakes to instruction and data memory. It emits the one-cycle enables that tell the register file and datapath when to act, and traps on unsupported opcodes or misaligned control transfers.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- imem_req  out  1  instruction fetch request, held high until imem_ack
- imem_addr  out  32  fetch address, equals pc
- imem_ack  in  1  instruction memory response valid
- imem_rdata  in  32  instruction word, sampled when imem_ack=1 in FETCH
- inst  out  32  latched instruction register
- pc  out  32  address of current instruction
- ex_valid  out  1  one-cycle pulse in EXECUTE; datapath computes ALU/address result
- branch_taken  in  1  datapath redirect decision, sampled in EXECUTE
- branch_target  in  32  redirect address, sampled in EXECUTE
- dmem_req  out  1  load/store request, held high until dmem_ack
- dmem_we  out  1  1 for STORE, 0 for LOAD; valid while dmem_req=1
- dmem_ack  in  1  data memory completion
- rf_we  out  1  one-cycle register-file write enable in WRITEBACK
- retire  out  1  one-cycle pulse when an instruction completes
- instret  out  32  retired-instruction counter
- trap  out  1  sticky; high in TRAP state

## Operation
- States: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP. Reset enters FETCH.
- FETCH: imem_req=1, imem_addr=pc. When imem_ack=1, inst<=imem_rdata and go to DECODE. Otherwise stay.
- DECODE: classify inst[6:0].
  - Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111.
  - Any other opcode, or inst[1:0]!=2'b11, goes to TRAP. Otherwise go to EXECUTE.
- EXECUTE: ex_valid=1 for exactly one cycle. Register branch_taken and branch_target.
  - LOAD or STORE goes to MEM. Everything else goes to WRITEBACK.
- MEM: dmem_req=1; dmem_we=1 only for STORE. On dmem_ack=1 go to WRITEBACK.
- WRITEBACK:
  - rf_we=1 iff the opcode is not STORE/BRANCH and inst[11:7]!=0.
  - Next pc is the registered branch_target if the registered branch_taken=1, else pc+4.
  - retire=1 and instret<=instret+1, then go to FETCH.
- Misaligned redirect: if the registered taken=1 and target[1:0]!=0, WRITEBACK does not update pc and asserts neither rf_we nor retire. It goes to TRAP instead.
- TRAP: trap=1. pc and inst hold their values. All request and enable outputs are 0. Only reset exits TRAP.
- Arithmetic: pc+4 and instret+1 are modulo 2^32. 32'hFFFF_FFFC+4 wraps to 0; instret wraps to 0 with no flag.
- branch_taken is only meaningful for BRANCH/JAL/JALR. The controller applies it for any opcode; the datapath must drive 0 otherwise.

## Timing
- Reset values: pc=RESET_PC, inst=32'h0000_0013 (NOP), instret=0, state=FETCH. On the first edge after reset release, imem_req=1. All other outputs are 0.
- imem_req, dmem_req, dmem_we, ex_valid, rf_we, retire and trap are decoded from the state register only. They do not depend combinationally on any input.
- Acks are sampled only in their own state. imem_ack in any state other than FETCH is ignored, and dmem_ack outside MEM is ignored.
- An ack in the first request cycle advances on that edge.
- With zero-wait acks, latency is:
  - 4 cycles per ALU/branch/jump instruction (FETCH, DECODE, EXECUTE, WRITEBACK).
  - 5 cycles per LOAD/STORE.
  - Each wait cycle adds 1.
- The retire pulse and the new pc appear on the same edge. The next imem_req with the new pc is asserted the following cycle.
- Reset mid-operation, e.g. during MEM with dmem_req=1: all requests drop immediately and asynchronously, and the in-flight instruction is discarded. A late ack after reset release is ignored unless the controller is in the matching state.

## Test plan
- Reset with RESET_PC=0, zero-wait memories; fetch 32'h002081B3 (add x3,x1,x2) -> imem_req high, 4 cycles later retire=1 with rf_we=1, pc=4, instret=1.
- LOAD 32'h0000A183 with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0, rf_we in the cycle after ack, total 8 cycles.
- BRANCH with branch_taken=1, target=32'h100 -> rf_we=0, pc=32'h100; then taken=1 with target=32'h102 -> trap=1, pc unchanged, retire=0.
- Illegal word 32'hFFFFFFFF -> TRAP after DECODE, trap stays high for 20 cycles, imem_req=0; reset -> pc=RESET_PC, trap=0.
- pc=32'hFFFF_FFFC plus ALU op -> pc wraps to 0; write to rd=0 (32'h00208033) -> rf_we=0 but retire=1.
- Assert reset during MEM with ack pending -> dmem_req=0 the same cycle; ack after release ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/core_ctrl.sv
// core_ctrl -- multi-cycle sequencer for a single-issue RV32I core.
//
// Steps each instruction through FETCH, DECODE, EXECUTE, (MEM), WRITEBACK.
// Owns the program counter, the instruction register and the retired-
// instruction counter. Traps on unsupported opcodes and misaligned redirects.
//
// Handshakes: a request (imem_req / dmem_req) is held high for as long as the
// FSM sits in the requesting state; the matching ack is sampled on each rising
// edge only in that state, and an ack in the first request cycle completes the
// transfer on that edge. Acks arriving in any other state are ignored.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   imem_req/addr       instruction fetch request and address (= pc)
//   imem_ack/rdata      fetch completion and instruction word
//   inst, pc            instruction register, current instruction address
//   ex_valid            one-cycle EXECUTE strobe to the datapath
//   branch_taken/target redirect decision/address, sampled in EXECUTE
//   dmem_req/we/ack     load/store request, store flag, completion
//   rf_we               register-file write enable (WRITEBACK)
//   retire, instret     completion pulse, retired-instruction counter
//   trap                high while in TRAP
//   dbg_state           current FSM state encoding, for observation only
module core_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        ex_valid,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        rf_we,
  output logic        retire,
  output logic [31:0] instret,
  output logic        trap,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] instret_q, instret_d;
  logic        taken_q, taken_d;
  logic [31:0] target_q, target_d;

  logic [6:0] opcode;
  logic       op_legal;
  logic       op_mem;
  logic       op_store;
  logic       op_writes_rd;
  logic       redirect_misaligned;

  assign opcode   = inst_q[6:0];
  assign op_store = (opcode == OP_STORE);
  assign op_mem   = (opcode == OP_LOAD) || op_store;

  always_comb begin
    op_legal = 1'b0;
    case (opcode)
      OP_REG, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: op_legal = 1'b1;
      default:                           op_legal = 1'b0;
    endcase
    // All legal opcodes already end in 2'b11; kept explicit for clarity.
    if (inst_q[1:0] != 2'b11) op_legal = 1'b0;
  end

  assign op_writes_rd        = !op_store && (opcode != OP_BRANCH) && (inst_q[11:7] != 5'd0);
  assign redirect_misaligned = taken_q && (target_q[1:0] != 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      inst_q    <= 32'h0000_0013;
      instret_q <= 32'd0;
      taken_q   <= 1'b0;
      target_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      instret_q <= instret_d;
      taken_q   <= taken_d;
      target_q  <= target_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    instret_d = instret_q;
    taken_d   = taken_q;
    target_d  = target_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          inst_d  = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = op_legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        taken_d  = branch_taken;
        target_d = branch_target;
        state_d  = op_mem ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (dmem_ack) state_d = S_WB;
      end
      S_WB: begin
        if (redirect_misaligned) begin
          state_d = S_TRAP;
        end else begin
          pc_d      = taken_q ? target_q : pc_q + 32'd4;
          instret_d = instret_q + 32'd1;
          state_d   = S_FETCH;
        end
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  // Strobes come from registered state only; the fetch request is also
  // masked by reset so that every request drops the moment reset asserts.
  assign imem_req  = (state_q == S_FETCH) && !reset;
  assign imem_addr = pc_q;
  assign ex_valid  = (state_q == S_EXEC);
  assign dmem_req  = (state_q == S_MEM);
  assign dmem_we   = (state_q == S_MEM) && op_store;
  assign rf_we     = (state_q == S_WB) && !redirect_misaligned && op_writes_rd;
  assign retire    = (state_q == S_WB) && !redirect_misaligned;
  assign trap      = (state_q == S_TRAP);
  assign inst      = inst_q;
  assign pc        = pc_q;
  assign instret   = instret_q;
  assign dbg_state = state_q;

endmodule
